// File: rtl/mem_stage.sv
// MEM pipeline stage: load data alignment, stall hold, handoff to WB.
// Optional unaligned loads (lwl/lwr) are enabled by MS_UNALIGNED_LOAD_EN.
module mem_stage (
    input  logic         clk,
    input  logic         reset,
    input  logic         es_to_ms_valid,
    input  logic [109:0] es_to_ms_bus,
    input  logic [9:0]   es_to_ms_addr,
    output logic         ms_allowin,
    input  logic         ws_allowin,
    input  logic         ms_stall,
    input  logic [31:0]  data_sram_rdata,
    output logic         ms_to_ws_valid,
    output logic [69:0]  ms_to_ws_bus,
    output logic [9:0]   ms_to_ws_addr,
    output logic [31:0]  ms_forward,
    output logic         ms_valid_tohazard
);

`ifdef MS_UNALIGNED_LOAD_EN
    localparam int BW = 110;
`else
    localparam int BW = 76;
    logic unused_rt_bits;
    assign unused_rt_bits = ^es_to_ms_bus[109:76];
`endif

    logic          ms_valid_q;
    logic          first_q;
    logic [31:0]   hold_q;
    logic [BW-1:0] bus_q;
    logic [9:0]    addr_q;

    logic        ms_ready_go;
    logic        load_en;
    logic [31:0] ld_data;
    logic [31:0] final_result;
    logic [15:0] half;
    logic [7:0]  byte_v;

    logic        ld_w;
    logic        ld_h;
    logic        ld_b;
    logic        ld_sign;
    logic [1:0]  addr_lo;
    logic        gr_we;
    logic [4:0]  dest;
    logic [31:0] alu_result;
    logic [31:0] pc;

    assign ld_w       = bus_q[75];
    assign ld_h       = bus_q[74];
    assign ld_b       = bus_q[73];
    assign ld_sign    = bus_q[72];
    assign addr_lo    = bus_q[71:70];
    assign gr_we      = bus_q[69];
    assign dest       = bus_q[68:64];
    assign alu_result = bus_q[63:32];
    assign pc         = bus_q[31:0];

    assign ms_ready_go = !ms_stall;
    assign ms_allowin  = !ms_valid_q || (ms_ready_go && ws_allowin);
    assign load_en     = es_to_ms_valid && ms_allowin;

    // Valid bit and first-cycle flag; the flag marks the cycle rdata is live.
    always_ff @(posedge clk) begin
        if (reset) begin
            ms_valid_q <= 1'b0;
            first_q    <= 1'b0;
        end else begin
            if (ms_allowin) begin
                ms_valid_q <= es_to_ms_valid;
            end
            first_q <= load_en;
        end
    end

    // Capture live load data so a stalled instruction keeps its result.
    always_ff @(posedge clk) begin
        if (reset) begin
            hold_q <= 32'h0;
        end else if (first_q) begin
            hold_q <= data_sram_rdata;
        end
    end

    // Instruction payload registers, loaded on accepted handoff from EX.
    always_ff @(posedge clk) begin
        if (load_en) begin
            bus_q  <= es_to_ms_bus[BW-1:0];
            addr_q <= es_to_ms_addr;
        end
    end

    assign ld_data = first_q ? data_sram_rdata : hold_q;
    assign half    = addr_lo[1] ? ld_data[31:16] : ld_data[15:0];

    // Byte lane select by low address bits.
    always_comb begin
        byte_v = ld_data[7:0];
        case (addr_lo)
            2'd0: byte_v = ld_data[7:0];
            2'd1: byte_v = ld_data[15:8];
            2'd2: byte_v = ld_data[23:16];
            2'd3: byte_v = ld_data[31:24];
            default: byte_v = ld_data[7:0];
        endcase
    end

`ifdef MS_UNALIGNED_LOAD_EN
    logic        lwl;
    logic        lwr;
    logic [31:0] rt;
    logic [31:0] lwl_v;
    logic [31:0] lwr_v;

    assign lwl = bus_q[109];
    assign lwr = bus_q[108];
    assign rt  = bus_q[107:76];

    // Merge loaded bytes with the old rt value for unaligned loads.
    always_comb begin
        lwl_v = ld_data;
        lwr_v = ld_data;
        case (addr_lo)
            2'd0: begin
                lwl_v = {ld_data[7:0], rt[23:0]};
                lwr_v = ld_data;
            end
            2'd1: begin
                lwl_v = {ld_data[15:0], rt[15:0]};
                lwr_v = {rt[31:24], ld_data[31:8]};
            end
            2'd2: begin
                lwl_v = {ld_data[23:0], rt[7:0]};
                lwr_v = {rt[31:16], ld_data[31:16]};
            end
            2'd3: begin
                lwl_v = ld_data;
                lwr_v = {rt[31:8], ld_data[31:24]};
            end
            default: begin
                lwl_v = ld_data;
                lwr_v = ld_data;
            end
        endcase
    end
`endif

    // Result select; non-load instructions pass the ALU result through.
    always_comb begin
        final_result = alu_result;
        if (ld_w) begin
            final_result = ld_data;
        end else if (ld_h) begin
            final_result = {{16{ld_sign & half[15]}}, half};
        end else if (ld_b) begin
            final_result = {{24{ld_sign & byte_v[7]}}, byte_v};
`ifdef MS_UNALIGNED_LOAD_EN
        end else if (lwl) begin
            final_result = lwl_v;
        end else if (lwr) begin
            final_result = lwr_v;
`endif
        end
    end

    assign ms_to_ws_valid    = ms_valid_q && ms_ready_go;
    assign ms_to_ws_bus      = {gr_we && ms_valid_q, dest, final_result, pc};
    assign ms_to_ws_addr     = addr_q;
    assign ms_forward        = final_result;
    assign ms_valid_tohazard = ms_valid_q;

endmodule

// File: doc/mem_stage.md
MEM_STAGE -- requirements
Module: mem_stage

Interface
REQ-001 clk  input  1  clock; all state updates on rising edge.
REQ-002 reset  input  1  reset, synchronous, active-high.
REQ-003 es_to_ms_valid  input  1  upstream EX has an instruction to hand over.
REQ-004 es_to_ms_bus  input  110  {lwl[109], lwr[108], rt_value[107:76], ld_w[75], ld_h[74], ld_b[73], ld_sign[72], addr_lo[71:70], gr_we[69], dest[68:64], alu_result[63:32], pc[31:0]}.
REQ-005 es_to_ms_addr  input  10  source register numbers {rs[9:5], rt[4:0]} for hazard tracking.
REQ-006 ms_allowin  output  1  MEM can accept from EX this cycle.
REQ-007 ws_allowin  input  1  WB can accept this cycle.
REQ-008 ms_stall  input  1  hazard-unit hold request for MEM.
REQ-009 data_sram_rdata  input  32  load data; valid exactly one cycle after the EX-stage request, i.e. the first cycle an instruction occupies MEM.
REQ-010 ms_to_ws_valid  output  1  MEM hands an instruction to WB.
REQ-011 ms_to_ws_bus  output  70  {gr_we[69], dest[68:64], final_result[63:32], pc[31:0]}.
REQ-012 ms_to_ws_addr  output  10  registered es_to_ms_addr.
REQ-013 ms_forward  output  32  final_result, for the EX forwarding mux.
REQ-014 ms_valid_tohazard  output  1  ms_valid.

Function
REQ-015 ms_ready_go SHALL be !ms_stall; ms_allowin SHALL be !ms_valid || (ms_ready_go && ws_allowin).
REQ-016 ms_to_ws_valid SHALL be ms_valid && ms_ready_go.
REQ-017 When ms_allowin is high, ms_valid SHALL load es_to_ms_valid; when es_to_ms_valid && ms_allowin, the bus and addr registers SHALL load. Otherwise they SHALL hold.
REQ-018 A 1-bit first-cycle flag SHALL be set on every bus-register load and cleared on the next cycle; in the first cycle, load data SHALL come from data_sram_rdata and SHALL be captured into a 32-bit hold register; in later cycles (stalled), load data SHALL come from the hold register.
REQ-019 ld_w: result = data.
REQ-020 ld_h: half = addr_lo[1] ? data[31:16] : data[15:0]; sign-extended if ld_sign, else zero-extended.
REQ-021 ld_b: byte = data[8*addr_lo+7 : 8*addr_lo]; sign/zero-extended per ld_sign.
REQ-022 lwl by addr_lo 0/1/2/3: {data[7:0],rt[23:0]} / {data[15:0],rt[15:0]} / {data[23:0],rt[7:0]} / data.
REQ-023 lwr by addr_lo 0/1/2/3: data / {rt[31:24],data[31:8]} / {rt[31:16],data[31:16]} / {rt[31:8],data[31:24]}.
REQ-024 No load flag set: final_result = alu_result; more than one load flag set is illegal input, no defined result.
REQ-025 ms_to_ws_bus gr_we SHALL be gr_we && ms_valid.
REQ-026 Back-to-back: a new instruction loaded while the previous one leaves SHALL see the first-cycle flag set and use live rdata.
REQ-027 ms_stall and ws_allowin=0 simultaneously: hold; release SHALL present the held result unchanged.

Reset
REQ-028 On reset: ms_valid=0, first-cycle flag=0, hold register=0; hence ms_to_ws_valid=0, ms_allowin=1, ms_valid_tohazard=0; bus/addr registers are don't-care.
REQ-029 Reset mid-stall SHALL discard the held instruction; no output valid in the following cycle unless a new load occurs.

Configuration
REQ-030 Macro MS_UNALIGNED_LOAD_EN defined: REQ-022/023 implemented.
REQ-031 Macro undefined: lwl/lwr bits ignored; such instructions SHALL return alu_result per REQ-024 and no rt-merge logic SHALL be synthesized.

Verification
REQ-032 lb, sign=1, addr_lo=2, rdata=0x12F45678 -> final_result=0xFFFFFFF4; sign=0 -> 0x000000F4.
REQ-033 lh, addr_lo=2, sign=1, rdata=0x8001ABCD -> 0xFFFF8001.
REQ-034 lwl addr_lo=1, rt=0xAABBCCDD, rdata=0x11223344 -> 0x3344CCDD; lwr addr_lo=1 same data -> 0xAA112233 (macro defined); undefined -> alu_result.
REQ-035 lw, rdata=0xDEADBEEF in first cycle, ms_stall=1 for 3 cycles while rdata changes to 0 -> ms_to_ws_valid=0 during stall, then 0xDEADBEEF with valid=1.
REQ-036 ws_allowin=0 with ms_valid=1 -> ms_allowin=0, registers hold; ws_allowin=1 and es_to_ms_valid=1 -> next instruction loaded in same edge, no bubble.
REQ-037 reset asserted during a stalled load -> next cycle ms_valid=0, ms_allowin=1, ms_to_ws_valid=0.
